// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the single-port SISC memory between the instruction-fetch
//            requester (IF) and the data requester (DM). A request seen in
//            IDLE is arbitrated, and its address, write-enable and write data
//            are captured. The memory strobes are held for MEM_LAT cycles.
//            The owner's read data is then registered and its done strobe
//            pulses for one cycle.
// Options  : MEM_ARB_RR_EN - when defined, a tie goes to the requester that
//            was not granted last (round robin). When undefined, DM always
//            wins a tie.
// Ports    : clk, rst_f             - clock (rising edge), async active-low reset
//            if_req/if_addr         - fetch request level and address
//            if_done/if_rdata       - fetch complete pulse, fetched word (held)
//            dm_req/dm_we/dm_addr/dm_wdata - data request, store flag, address, data
//            dm_done/dm_rdata       - data complete pulse, load data (held)
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//            busy                   - high whenever the arbiter is not idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2      // access cycles per transaction, 1..15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic              owner_dm_q, owner_dm_d;   // 0 = IF, 1 = DM
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm;

`ifdef MEM_ARB_RR_EN
    // Owner of the most recent grant; resets to IF so DM wins the first tie.
    logic              last_dm_q,  last_dm_d;

    assign grant_dm = dm_req & (~if_req | ~last_dm_q);
`else
    assign grant_dm = dm_req;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_dm_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_dm_q  <= last_dm_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and output decode. The outputs depend only on
    // registered state, so no request input reaches the memory port
    // combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_dm_d  = last_dm_q;
`endif

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        busy      = (state_q != S_IDLE);
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_d    = S_ACCESS;
                    cnt_d      = C_CNT_INIT;
                    owner_dm_d = grant_dm;
                    we_d       = grant_dm & dm_we;
                    addr_d     = grant_dm ? dm_addr : if_addr;
                    wdata_d    = grant_dm ? dm_wdata : '0;
`ifdef MEM_ARB_RR_EN
                    last_dm_d  = grant_dm;
`endif
                end
            end

            S_ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = owner_dm_q & we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    // Last access cycle: memory data is valid now.
                    if (!owner_dm_q) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DONE: begin
                if_done = ~owner_dm_q;
                dm_done = owner_dm_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
